sccb_config_scheduler: RTL and testbench
========================================

# sccb_config_scheduler

Sequencer and arbiter in front of the single SCCB write engine that programs the OV7670. After `start`, it waits out camera power-up, then walks the boot register ROM and issues one SCCB write per entry, honouring delay markers. Once boot finishes, it shares the engine between two runtime requesters, such as exposure/gain tuning and a debug register poke, using round-robin arbitration.

## Interface
- `POWERUP_CYCLES`, default 1_000_000: idle cycles after `start` before the first write (10 ms at 100 MHz).
- `DELAY_CYCLES`, default 1_000_000: wait inserted for a ROM delay marker.
- `ROM_AW`, default 8: ROM address width.
- `clk`, in, 1: system clock (100 MHz).
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins the boot sequence.
- `rom_addr`, out, ROM_AW: boot ROM address.
- `rom_data`, in, 16: ROM word {reg[15:8], val[7:0]}, valid 1 cycle after `rom_addr` changes.
- `sccb_start`, out, 1: one-cycle pulse that launches a write.
- `sccb_addr`, out, 8: register address, held stable from `sccb_start` until `sccb_done`.
- `sccb_data`, out, 8: register value, held stable from `sccb_start` until `sccb_done`.
- `sccb_ready`, in, 1: engine idle.
- `sccb_done`, in, 1: one-cycle pulse when the write completes.
- `req0_valid`, in, 1: requester 0 write request.
- `req0_addr`, in, 8: requester 0 register address.
- `req0_data`, in, 8: requester 0 register value.
- `req0_ack`, out, 1: requester 0 completion pulse.
- `req1_valid`, in, 1: requester 1 write request.
- `req1_addr`, in, 8: requester 1 register address.
- `req1_data`, in, 8: requester 1 register value.
- `req1_ack`, out, 1: requester 1 completion pulse.
- `config_done`, out, 1: boot sequence complete.
- `busy`, out, 1: a sequence or write is in progress.

## Operation
- States: IDLE, PWRUP, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, READY, GRANT.
- IDLE:
  - `start` moves to PWRUP.
  - The counter loads POWERUP_CYCLES-1.
  - `rom_addr` is set to 0.
  - `config_done` is cleared.
- PWRUP: count down to 0, then go to FETCH.
- FETCH: present `rom_addr`, wait 1 cycle, go to DECODE.
- DECODE:
  - 0xFFFF goes to READY and sets `config_done`.
  - 0xFFF0 goes to DELAY, loading DELAY_CYCLES-1.
  - Any other value latches reg/val into `sccb_addr`/`sccb_data` and goes to ISSUE.
- ISSUE: when `sccb_ready`=1, pulse `sccb_start` for 1 cycle and go to WAIT_DONE. Otherwise stay in ISSUE.
- WAIT_DONE:
  - Wait for `sccb_done`.
  - In boot, increment `rom_addr` and go to FETCH.
  - In runtime, pulse the owner's `reqN_ack` in the cycle after `sccb_done` and go to READY.
- DELAY: count down to 0, increment `rom_addr`, go to FETCH.
- READY:
  - If any `reqN_valid` is set, pick a winner round-robin; the priority pointer favours the requester not granted last (requester 0 after reset).
  - Latch the winner's addr/data and go to ISSUE.
- A requester holds valid/addr/data until its ack. Valid dropped before grant is permitted. After grant, the latched values are used.
- ROM address wrap: if `rom_addr` reaches 2^ROM_AW-1 without the end marker, treat it as the end marker.
- `start` outside IDLE/READY is ignored. `start` in READY restarts boot from PWRUP and clears `config_done`; pending requests wait.
- `busy` = state not in {IDLE, READY}.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer selects requester 0.
- Reset mid-write drops the transaction and sends no ack. The engine is reset by the same `reset`.
- `start` registers in PWRUP on the next edge.
- The first `sccb_start` comes no earlier than POWERUP_CYCLES+3 cycles after `start`.
- Per ROM entry overhead: 3 cycles (FETCH, DECODE, ISSUE) plus the engine time.
- Grant latency: READY to `sccb_start` in 2 cycles if `sccb_ready`=1.
- `reqN_ack` is exactly 1 cycle, 1 cycle after `sccb_done`.
- Never more than one `sccb_start` per `sccb_done`.
- `sccb_done` arriving outside WAIT_DONE is ignored.
- Simultaneous `req0_valid`/`req1_valid`: grants alternate 0,1,0,1 while both stay asserted.
- A request arriving during boot is served only after `config_done`.

## Test plan
- ROM {0x1280, 0x1100, 0xFFFF}, POWERUP_CYCLES=20, engine model with 50-cycle writes, `start` pulse -> exactly 2 `sccb_start` with addr/data 12/80 then 11/00; `config_done` rises after the second `sccb_done`; first start at ≥ start+23 cycles.
- ROM {0x1280, 0xFFF0, 0x1100, 0xFFFF}, DELAY_CYCLES=30 -> gap between first `sccb_done` and second `sccb_start` ≥ 32 cycles.
- After `config_done`, hold `req0_valid`/`req1_valid` with 3A/01 and 3B/02 for 4 transactions -> grants in order req0, req1, req0, req1; each `reqN_ack` is 1 cycle long with the matching addr/data.
- `sccb_ready` held low for 10 cycles in ISSUE -> no `sccb_start` until `sccb_ready` rises; addr/data stable throughout.
- `reset` asserted in WAIT_DONE -> all outputs 0 next cycle; state returns to IDLE; no ack; a new `start` replays the ROM from entry 0.
- `start` during boot is ignored (write count unchanged). `start` in READY with `req0_valid` pending -> full ROM is replayed first, then req0 is served and acked.

Source files
------------

// File: rtl/sccb_config_scheduler.sv
// Boot-time OV7670 register sequencer and round-robin arbiter that shares the
// single SCCB write engine between two runtime requesters once boot completes.
module sccb_config_scheduler #(
  parameter int unsigned POWERUP_CYCLES = 1_000_000,
  parameter int unsigned DELAY_CYCLES   = 1_000_000,
  parameter int unsigned ROM_AW         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_data,
  input  logic              sccb_ready,
  input  logic              sccb_done,
  input  logic              req0_valid,
  input  logic [7:0]        req0_addr,
  input  logic [7:0]        req0_data,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [7:0]        req1_addr,
  input  logic [7:0]        req1_data,
  output logic              req1_ack,
  output logic              config_done,
  output logic              busy
);

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;
  localparam logic [31:0] PWRUP_LOAD = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] DELAY_LOAD = 32'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, READY, GRANT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cnt;
  logic        booting;
  logic        owner;
  logic        prio;

  logic cnt_zero;
  logic rom_end;
  logic rom_delay;
  logic boot_kick;
  logic req0_eff;
  logic req1_eff;
  logic any_req;
  logic winner;

  assign cnt_zero  = (cnt == '0);
  // The last ROM address doubles as an end marker so a ROM missing 0xFFFF
  // still terminates instead of wrapping back to entry 0.
  assign rom_end   = (rom_data == END_MARK) || (&rom_addr);
  assign rom_delay = (rom_data == DELAY_MARK);
  assign boot_kick = start && ((state == IDLE) || (state == READY));

  // A requester still shows valid during its ack cycle; masking it there keeps
  // one request from being served twice.
  assign req0_eff = req0_valid && !req0_ack;
  assign req1_eff = req1_valid && !req1_ack;
  assign any_req  = req0_eff || req1_eff;
  assign winner   = (req0_eff && req1_eff) ? prio : req1_eff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = PWRUP;
      PWRUP:     if (cnt_zero) state_nxt = FETCH;
      FETCH:     state_nxt = DECODE;
      DECODE: begin
        if (rom_end)        state_nxt = READY;
        else if (rom_delay) state_nxt = DELAY;
        else                state_nxt = ISSUE;
      end
      ISSUE:     if (sccb_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (sccb_done) state_nxt = booting ? FETCH : READY;
      DELAY:     if (cnt_zero) state_nxt = FETCH;
      READY: begin
        if (start)        state_nxt = PWRUP;
        else if (any_req) state_nxt = GRANT;
      end
      GRANT:     state_nxt = ISSUE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sccb_start = (state == ISSUE) && sccb_ready;
    busy       = (state != IDLE) && (state != READY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rom_addr    <= '0;
      sccb_addr   <= '0;
      sccb_data   <= '0;
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
      config_done <= 1'b0;
      booting     <= 1'b0;
      owner       <= 1'b0;
      prio        <= 1'b0;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      if (boot_kick) begin
        cnt         <= PWRUP_LOAD;
        rom_addr    <= '0;
        config_done <= 1'b0;
        booting     <= 1'b1;
      end else begin
        case (state)
          PWRUP: if (!cnt_zero) cnt <= cnt - 1'b1;
          DELAY: begin
            if (cnt_zero) rom_addr <= rom_addr + 1'b1;
            else          cnt      <= cnt - 1'b1;
          end
          DECODE: begin
            if (rom_end) begin
              config_done <= 1'b1;
              booting     <= 1'b0;
            end else if (rom_delay) begin
              cnt <= DELAY_LOAD;
            end else begin
              sccb_addr <= rom_data[15:8];
              sccb_data <= rom_data[7:0];
            end
          end
          WAIT_DONE: begin
            if (sccb_done) begin
              if (booting)    rom_addr <= rom_addr + 1'b1;
              else if (owner) req1_ack <= 1'b1;
              else            req0_ack <= 1'b1;
            end
          end
          READY: begin
            if (any_req) begin
              owner     <= winner;
              prio      <= ~winner;
              sccb_addr <= winner ? req1_addr : req0_addr;
              sccb_data <= winner ? req1_data : req0_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_config_scheduler.sv
// Directed bench for sccb_config_scheduler with a 50-cycle SCCB engine model,
// a synchronous boot ROM model and a protocol monitor on the ack outputs.
module tb_sccb_config_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        sccb_start;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_ready;
  logic        sccb_done = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_addr = '0;
  logic [7:0]  req0_data = '0;
  logic        req0_ack;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_addr = '0;
  logic [7:0]  req1_data = '0;
  logic        req1_ack;
  logic        config_done;
  logic        busy;

  sccb_config_scheduler #(
    .POWERUP_CYCLES(20),
    .DELAY_CYCLES  (30),
    .ROM_AW        (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sccb_start (sccb_start),
    .sccb_addr  (sccb_addr),
    .sccb_data  (sccb_data),
    .sccb_ready (sccb_ready),
    .sccb_done  (sccb_done),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ack   (req1_ack),
    .config_done(config_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [15:0] rom [16];
  logic        eng_busy  = 1'b0;
  int          eng_cnt   = 0;
  logic        force_low = 1'b0;
  logic [7:0]  lat_addr  = '0;
  logic [7:0]  lat_data  = '0;

  int         start_count = 0;
  int         done_count  = 0;
  int         ack_count   = 0;
  int         stable_err  = 0;
  int         proto_err   = 0;
  int         ack_err     = 0;
  logic [7:0] log_addr [512];
  logic [7:0] log_data [512];
  int         log_cyc  [512];
  int         done_cyc [512];
  int         ack_log  [512];
  logic       done_prev = 1'b0;
  logic       ack0_prev = 1'b0;
  logic       ack1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  assign sccb_ready = !eng_busy && !force_low;

  // Engine model: accepts a start when ready, completes 50 cycles later.
  always @(posedge clk) begin
    sccb_done <= 1'b0;
    if (reset) begin
      eng_busy <= 1'b0;
    end else begin
      if (eng_busy) begin
        if (sccb_addr !== lat_addr || sccb_data !== lat_data) stable_err++;
        if (eng_cnt == 1) begin
          eng_busy  <= 1'b0;
          sccb_done <= 1'b1;
          done_cyc[done_count] = cyc + 1;
          done_count++;
        end
        eng_cnt <= eng_cnt - 1;
      end
      if (sccb_start) begin
        if (!sccb_ready) begin
          proto_err++;
        end else begin
          eng_busy <= 1'b1;
          eng_cnt  <= 50;
          lat_addr <= sccb_addr;
          lat_data <= sccb_data;
          log_addr[start_count] = sccb_addr;
          log_data[start_count] = sccb_data;
          log_cyc[start_count]  = cyc;
          start_count++;
        end
      end
    end
  end

  always @(posedge clk) begin
    done_prev <= sccb_done;
    ack0_prev <= req0_ack;
    ack1_prev <= req1_ack;
    if ((req0_ack || req1_ack) &&
        (!done_prev || (req0_ack && ack0_prev) || (req1_ack && ack1_prev) || (req0_ack && req1_ack)))
      ack_err++;
    if (req0_ack) begin ack_log[ack_count] = 0; ack_count++; end
    if (req1_ack) begin ack_log[ack_count] = 1; ack_count++; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(output int at);
    @(negedge clk);
    start = 1'b1;
    at    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cfg(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (config_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (req0_ack || req1_ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_starts(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (start_count >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; force_low = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({sccb_start, req0_ack, req1_ack, config_done, busy} !== 5'b0) begin
      n_mis++;
      $display("FAIL reset_flags got=%b want=00000", {sccb_start, req0_ack, req1_ack, config_done, busy});
    end
    n_cmp++;
    if ({rom_addr, sccb_addr, sccb_data} !== 20'h0) begin
      n_mis++;
      $display("FAIL reset_buses got=%h want=00000", {rom_addr, sccb_addr, sccb_data});
    end
  endtask

  task automatic test_boot();
    int s0, d0, t0;
    bit ok;
    load_rom(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    s0 = start_count; d0 = done_count;
    pulse_start(t0);
    n_cmp++;
    if (busy !== 1'b1) begin n_mis++; $display("FAIL boot_busy got=%b want=1", busy); end
    wait_cfg(3000, ok);
    n_cmp++;
    if (!ok) begin n_mis++; $display("FAIL boot_timeout got=no config_done want=config_done"); end
    n_cmp++;
    if (start_count - s0 !== 2) begin n_mis++; $display("FAIL boot_count got=%0d want=2", start_count - s0); end
    n_cmp++;
    if ({log_addr[s0], log_data[s0], log_addr[s0+1], log_data[s0+1]} !== 32'h1280_1100) begin
      n_mis++;
      $display("FAIL boot_writes got=%h%h %h%h want=1280 1100", log_addr[s0], log_data[s0], log_addr[s0+1], log_data[s0+1]);
    end
    n_cmp++;
    if (done_count - d0 !== 2) begin n_mis++; $display("FAIL config_done_timing dones=%0d want=2", done_count - d0); end
    n_cmp++;
    if (log_cyc[s0] - t0 < 23) begin n_mis++; $display("FAIL first_start_latency got=%0d want>=23", log_cyc[s0] - t0); end
    n_cmp++;
    if (busy !== 1'b0) begin n_mis++; $display("FAIL ready_busy got=%b want=0", busy); end
  endtask

  task automatic test_delay();
    int s0, d0, t0;
    bit ok;
    do_reset();
    load_rom(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF);
    s0 = start_count; d0 = done_count;
    pulse_start(t0);
    wait_cfg(3000, ok);
    n_cmp++;
    if (!ok || start_count - s0 !== 2) begin
      n_mis++; $display("FAIL delay_count ok=%0d got=%0d want=2", ok, start_count - s0);
    end
    n_cmp++;
    if ({log_addr[s0+1], log_data[s0+1]} !== 16'h1100) begin
      n_mis++; $display("FAIL delay_second_write got=%h%h want=1100", log_addr[s0+1], log_data[s0+1]);
    end
    n_cmp++;
    if (log_cyc[s0+1] - done_cyc[d0] < 32) begin
      n_mis++; $display("FAIL delay_gap got=%0d want>=32", log_cyc[s0+1] - done_cyc[d0]);
    end
  endtask

  task automatic test_round_robin();
    int s0, a0, t0, got;
    got = 0;
    @(negedge clk);
    req0_addr = 8'h3A; req0_data = 8'h01; req0_valid = 1'b1;
    req1_addr = 8'h3B; req1_data = 8'h02; req1_valid = 1'b1;
    s0 = start_count; a0 = ack_count; t0 = cyc;
    for (int i = 0; i < 2000 && got < 4; i++) begin
      @(negedge clk);
      if (req0_ack || req1_ack) got++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(3);
    n_cmp++;
    if (got !== 4) begin n_mis++; $display("FAIL rr_acks got=%0d want=4", got); end
    n_cmp++;
    if (ack_log[a0] !== 0 || ack_log[a0+1] !== 1 || ack_log[a0+2] !== 0 || ack_log[a0+3] !== 1) begin
      n_mis++;
      $display("FAIL rr_order got=%0d%0d%0d%0d want=0101", ack_log[a0], ack_log[a0+1], ack_log[a0+2], ack_log[a0+3]);
    end
    n_cmp++;
    if ({log_addr[s0], log_data[s0], log_addr[s0+1], log_data[s0+1],
         log_addr[s0+2], log_data[s0+2], log_addr[s0+3], log_data[s0+3]} !== 64'h3A01_3B02_3A01_3B02) begin
      n_mis++;
      $display("FAIL rr_writes got=%h%h %h%h %h%h %h%h want=3A01 3B02 3A01 3B02",
               log_addr[s0], log_data[s0], log_addr[s0+1], log_data[s0+1],
               log_addr[s0+2], log_data[s0+2], log_addr[s0+3], log_data[s0+3]);
    end
    n_cmp++;
    if (log_cyc[s0] - t0 !== 2) begin n_mis++; $display("FAIL grant_latency got=%0d want=2", log_cyc[s0] - t0); end
    n_cmp++;
    if (start_count - s0 !== 4) begin n_mis++; $display("FAIL rr_start_count got=%0d want=4", start_count - s0); end
    n_cmp++;
    if (ack_err !== 0) begin n_mis++; $display("FAIL ack_protocol errors=%0d want=0", ack_err); end
  endtask

  task automatic test_ready_low();
    int s0, a0, bad_start, bad_hold;
    bit ok;
    bad_start = 0; bad_hold = 0;
    @(negedge clk);
    req0_addr = 8'h55; req0_data = 8'hAA; req0_valid = 1'b1; force_low = 1'b1;
    s0 = start_count; a0 = ack_count;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sccb_start !== 1'b0) bad_start++;
      if ({sccb_addr, sccb_data} !== 16'h55AA || busy !== 1'b1) bad_hold++;
    end
    n_cmp++;
    if (bad_start !== 0 || start_count !== s0) begin
      n_mis++; $display("FAIL ready_low_start got=%0d pulses want=0", bad_start + start_count - s0);
    end
    n_cmp++;
    if (bad_hold !== 0) begin n_mis++; $display("FAIL ready_low_hold got=%0d bad cycles want=0", bad_hold); end
    force_low = 1'b0;
    wait_ack(200, ok);
    req0_valid = 1'b0;
    tick(2);
    n_cmp++;
    if (!ok || start_count - s0 !== 1 || ack_count - a0 !== 1 || ack_log[a0] !== 0) begin
      n_mis++; $display("FAIL ready_low_serve ok=%0d starts=%0d acks=%0d want=1 1", ok, start_count - s0, ack_count - a0);
    end
    n_cmp++;
    if ({log_addr[s0], log_data[s0]} !== 16'h55AA || stable_err !== 0) begin
      n_mis++; $display("FAIL ready_low_data got=%h%h unstable=%0d want=55AA 0", log_addr[s0], log_data[s0], stable_err);
    end
  endtask

  task automatic test_reset_mid_write();
    int s0, s1, a0, t0;
    bit ok;
    do_reset();
    load_rom(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    s0 = start_count;
    pulse_start(t0);
    wait_starts(s0 + 1, 500, ok);
    tick(5);
    n_cmp++;
    if (!ok || busy !== 1'b1) begin n_mis++; $display("FAIL mid_write_setup ok=%0d busy=%b want=1 1", ok, busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sccb_start, req0_ack, req1_ack, config_done, busy, rom_addr, sccb_addr, sccb_data} !== 25'h0) begin
      n_mis++;
      $display("FAIL mid_write_reset got=%b %h %h%h want=all zero",
               {sccb_start, req0_ack, req1_ack, config_done, busy}, rom_addr, sccb_addr, sccb_data);
    end
    reset = 1'b0;
    a0 = ack_count; s1 = start_count;
    tick(100);
    n_cmp++;
    if (ack_count !== a0 || start_count !== s1 || busy !== 1'b0) begin
      n_mis++; $display("FAIL mid_write_quiet acks=%0d starts=%0d busy=%b want=0 0 0", ack_count - a0, start_count - s1, busy);
    end
    pulse_start(t0);
    wait_cfg(3000, ok);
    n_cmp++;
    if (!ok || start_count - s1 !== 2 || {log_addr[s1], log_data[s1], log_addr[s1+1], log_data[s1+1]} !== 32'h1280_1100) begin
      n_mis++;
      $display("FAIL mid_write_replay ok=%0d count=%0d first=%h%h want=2 1280", ok, start_count - s1, log_addr[s1], log_data[s1]);
    end
  endtask

  task automatic test_start_ignored();
    int s0, s1, a0, t0;
    bit ok;
    do_reset();
    load_rom(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    s0 = start_count;
    pulse_start(t0);
    tick(5);
    pulse_start(t0);
    wait_starts(s0 + 1, 500, ok);
    tick(10);
    pulse_start(t0);
    wait_cfg(3000, ok);
    n_cmp++;
    if (!ok || start_count - s0 !== 2) begin
      n_mis++; $display("FAIL start_in_boot ok=%0d count=%0d want=2", ok, start_count - s0);
    end
    @(negedge clk);
    req0_addr = 8'h3A; req0_data = 8'h01; req0_valid = 1'b1; start = 1'b1;
    a0 = ack_count; s1 = start_count;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (config_done !== 1'b0 || busy !== 1'b1) begin
      n_mis++; $display("FAIL restart_flags config_done=%b busy=%b want=0 1", config_done, busy);
    end
    wait_cfg(3000, ok);
    n_cmp++;
    if (!ok || ack_count !== a0 || start_count - s1 !== 2 ||
        {log_addr[s1], log_data[s1], log_addr[s1+1], log_data[s1+1]} !== 32'h1280_1100) begin
      n_mis++;
      $display("FAIL restart_replay ok=%0d acks=%0d count=%0d first=%h%h want=0 2 1280",
               ok, ack_count - a0, start_count - s1, log_addr[s1], log_data[s1]);
    end
    wait_ack(500, ok);
    req0_valid = 1'b0;
    tick(2);
    n_cmp++;
    if (!ok || ack_count - a0 !== 1 || ack_log[a0] !== 0 || {log_addr[s1+2], log_data[s1+2]} !== 16'h3A01) begin
      n_mis++;
      $display("FAIL restart_pending_req ok=%0d acks=%0d write=%h%h want=1 3A01", ok, ack_count - a0, log_addr[s1+2], log_data[s1+2]);
    end
  endtask

  task automatic test_rom_wrap();
    int s0, t0;
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = {8'(8'h20 + i), 8'(i)};
    s0 = start_count;
    pulse_start(t0);
    wait_cfg(3000, ok);
    n_cmp++;
    if (!ok || start_count - s0 !== 15) begin
      n_mis++; $display("FAIL wrap_count ok=%0d got=%0d want=15", ok, start_count - s0);
    end
    n_cmp++;
    if ({log_addr[s0+14], log_data[s0+14]} !== 16'h2E0E || rom_addr !== 4'hF) begin
      n_mis++; $display("FAIL wrap_last got=%h%h addr=%h want=2E0E F", log_addr[s0+14], log_data[s0+14], rom_addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    test_reset();
    test_boot();
    test_delay();
    test_round_robin();
    test_ready_low();
    test_reset_mid_write();
    test_start_ignored();
    test_rom_wrap();
    n_cmp++;
    if (proto_err !== 0 || ack_err !== 0 || stable_err !== 0) begin
      n_mis++; $display("FAIL protocol_totals start=%0d ack=%0d hold=%0d want=0 0 0", proto_err, ack_err, stable_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
